// File: rtl/scoreboard_pkg.sv
// Shared types and tag constants for the register scoreboard and the forwarding unit.
package scoreboard_pkg;
  localparam int SB_NREGS = 8;
  localparam int TAG_W    = 3;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [2:0]       reg_idx_t;

  typedef enum logic [1:0] {SB_RUN, SB_DRAIN, SB_HALTED} sb_state_e;

  // ALU results are forwardable from EX/MEM; load results are not yet.
  localparam tag_t ALU_TAG  = tag_t'(2);
  localparam tag_t LOAD_TAG = tag_t'(3);
endpackage

// File: rtl/sb_tag_cell.sv
// One register's writeback countdown tag: set on issue, otherwise decays to 0 per advance.
module sb_tag_cell
  import scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  input  logic set_en,
  input  tag_t set_val,
  output tag_t tag
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tag <= '0;
    else if (advance) begin
      if (set_en)        tag <= set_val;
      else if (tag != 0) tag <= tag - tag_t'(1);
    end
  end

  a_tag_range: assert property (@(posedge clk) disable iff (!rst_n) tag <= LOAD_TAG);
endmodule

// File: rtl/register_scoreboard.sv
// ID-stage hazard tracker: per-register tags, load-use stall, issue gating and halt/drain FSM.
module register_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NREGS = SB_NREGS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pipe_advance_i,
  input  logic                        issue_valid_i,
  input  logic                        issue_we_i,
  input  logic                        issue_load_i,
  input  logic [2:0]                  issue_rd_i,
  input  logic [2:0]                  src_ra_i,
  input  logic [2:0]                  src_rb_i,
  input  logic                        use_ra_i,
  input  logic                        use_rb_i,
  input  logic                        flush_i,
  input  logic                        halt_req_i,
  input  logic                        resume_i,
  output logic [NREGS-1:0][TAG_W-1:0] register_invalid_o,
  output logic                        load_use_stall_o,
  output logic                        issue_accept_o,
  output logic                        busy_o,
  output logic                        halted_o
);
  tag_t [NREGS-1:0] tags;
  logic [NREGS-1:0] set_en;
  tag_t             set_val;
  sb_state_e        state, state_nxt;

  assign set_val = issue_load_i ? LOAD_TAG : ALU_TAG;

  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    assign set_en[i] = issue_accept_o & issue_we_i & (issue_rd_i == reg_idx_t'(i));
    sb_tag_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (pipe_advance_i),
      .set_en  (set_en[i]),
      .set_val (set_val),
      .tag     (tags[i])
    );
  end

  assign register_invalid_o = tags;
  assign busy_o             = |tags;

  // A load tag still at LOAD_TAG cannot be forwarded yet; one bubble lets it decay.
  assign load_use_stall_o = issue_valid_i &
                            ((use_ra_i & (tags[src_ra_i] == LOAD_TAG)) |
                             (use_rb_i & (tags[src_rb_i] == LOAD_TAG)));

  assign issue_accept_o = issue_valid_i & pipe_advance_i & ~flush_i &
                          ~load_use_stall_o & (state == SB_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SB_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // Already idle on request: skip DRAIN and halt on the next edge.
      SB_RUN:    if (halt_req_i) state_nxt = busy_o ? SB_DRAIN : SB_HALTED;
      SB_DRAIN:  if (!halt_req_i)  state_nxt = SB_RUN;
                 else if (!busy_o) state_nxt = SB_HALTED;
      SB_HALTED: if (resume_i && !halt_req_i) state_nxt = SB_RUN;
      default:   state_nxt = SB_RUN;
    endcase
  end

  assign halted_o = (state == SB_HALTED);
endmodule

// File: tb/tb_register_scoreboard.sv
// Directed table-driven bench for register_scoreboard plus async-reset and idle-halt sequences.
module tb_register_scoreboard;
  logic             clk = 1'b0;
  logic             rst_n;
  logic             pipe_advance_i, issue_valid_i, issue_we_i, issue_load_i;
  logic [2:0]       issue_rd_i, src_ra_i, src_rb_i;
  logic             use_ra_i, use_rb_i, flush_i, halt_req_i, resume_i;
  logic [7:0][2:0]  register_invalid_o;
  logic             load_use_stall_o, issue_accept_o, busy_o, halted_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  register_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .pipe_advance_i(pipe_advance_i),
    .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i), .issue_load_i(issue_load_i),
    .issue_rd_i(issue_rd_i), .src_ra_i(src_ra_i), .src_rb_i(src_rb_i),
    .use_ra_i(use_ra_i), .use_rb_i(use_rb_i), .flush_i(flush_i),
    .halt_req_i(halt_req_i), .resume_i(resume_i),
    .register_invalid_o(register_invalid_o), .load_use_stall_o(load_use_stall_o),
    .issue_accept_o(issue_accept_o), .busy_o(busy_o), .halted_o(halted_o)
  );

  typedef struct {
    logic adv, vld, we, ld;
    logic [2:0] rd;
    logic ura; logic [2:0] ra;
    logic urb; logic [2:0] rb;
    logic fl, hlt, res;
    logic es, ea, eb;
    logic [7:0][2:0] et;
    logic eh;
  } vec_t;

  vec_t vecs[32];

  function automatic logic [7:0][2:0] tg(input int r7, r6, r5, r4, r3, r2, r1, r0);
    logic [7:0][2:0] t;
    t[7] = 3'(r7); t[6] = 3'(r6); t[5] = 3'(r5); t[4] = 3'(r4);
    t[3] = 3'(r3); t[2] = 3'(r2); t[1] = 3'(r1); t[0] = 3'(r0);
    return t;
  endfunction

  function automatic vec_t mk(input logic adv, vld, we, ld, input int rd,
                              input logic ura, input int ra, input logic urb, input int rb,
                              input logic fl, hlt, res, es, ea, eb,
                              input logic [7:0][2:0] et, input logic eh);
    vec_t v;
    v.adv = adv; v.vld = vld; v.we = we; v.ld = ld; v.rd = 3'(rd);
    v.ura = ura; v.ra = 3'(ra); v.urb = urb; v.rb = 3'(rb);
    v.fl = fl; v.hlt = hlt; v.res = res;
    v.es = es; v.ea = ea; v.eb = eb; v.et = et; v.eh = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    pipe_advance_i = 1'b1; issue_valid_i = 1'b0; issue_we_i = 1'b0; issue_load_i = 1'b0;
    issue_rd_i = '0; src_ra_i = '0; src_rb_i = '0; use_ra_i = 1'b0; use_rb_i = 1'b0;
    flush_i = 1'b0; halt_req_i = 1'b0; resume_i = 1'b0;
  endtask

  // Drive after negedge, check comb outputs before the edge, registered outputs after it.
  task automatic apply(input int idx, input vec_t v);
    pipe_advance_i = v.adv; issue_valid_i = v.vld; issue_we_i = v.we; issue_load_i = v.ld;
    issue_rd_i = v.rd; use_ra_i = v.ura; src_ra_i = v.ra; use_rb_i = v.urb; src_rb_i = v.rb;
    flush_i = v.fl; halt_req_i = v.hlt; resume_i = v.res;
    #1;
    check($sformatf("v%0d stall", idx), 32'(load_use_stall_o), 32'(v.es));
    check($sformatf("v%0d accept", idx), 32'(issue_accept_o), 32'(v.ea));
    check($sformatf("v%0d busy", idx), 32'(busy_o), 32'(v.eb));
    @(posedge clk); #1;
    check($sformatf("v%0d tags", idx), 32'(register_invalid_o), 32'(v.et));
    check($sformatf("v%0d halted", idx), 32'(halted_o), 32'(v.eh));
    @(negedge clk);
  endtask

  initial begin
    //         adv vld we ld rd ura ra urb rb fl hlt res es ea eb  tags r7..r0           halted
    vecs[0]  = mk(1,1,1,0,3, 0,0,0,0, 0,0,0, 0,1,0, tg(0,0,0,0,2,0,0,0), 0);
    vecs[1]  = mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,1, tg(0,0,0,0,1,0,0,0), 0);
    vecs[2]  = mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,1, tg(0,0,0,0,0,0,0,0), 0);
    vecs[3]  = mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, tg(0,0,0,0,0,0,0,0), 0);
    vecs[4]  = mk(1,1,1,1,2, 0,0,0,0, 0,0,0, 0,1,0, tg(0,0,0,0,0,3,0,0), 0);
    vecs[5]  = mk(1,1,1,0,6, 1,2,0,0, 0,0,0, 1,0,1, tg(0,0,0,0,0,2,0,0), 0);
    vecs[6]  = mk(1,1,1,0,6, 1,2,0,0, 0,0,0, 0,1,1, tg(0,2,0,0,0,1,0,0), 0);
    vecs[7]  = mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,1, tg(0,1,0,0,0,0,0,0), 0);
    vecs[8]  = mk(1,1,1,0,5, 0,0,0,0, 0,0,0, 0,1,1, tg(0,0,2,0,0,0,0,0), 0);
    vecs[9]  = mk(0,1,1,0,1, 0,0,0,0, 0,0,0, 0,0,1, tg(0,0,2,0,0,0,0,0), 0);
    vecs[10] = mk(0,1,1,0,1, 0,0,0,0, 0,0,0, 0,0,1, tg(0,0,2,0,0,0,0,0), 0);
    vecs[11] = mk(0,1,1,0,1, 0,0,0,0, 0,0,0, 0,0,1, tg(0,0,2,0,0,0,0,0), 0);
    vecs[12] = mk(1,1,1,0,4, 0,0,0,0, 0,0,0, 0,1,1, tg(0,0,1,2,0,0,0,0), 0);
    vecs[13] = mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,1, tg(0,0,0,1,0,0,0,0), 0);
    vecs[14] = mk(1,1,1,0,4, 0,0,0,0, 0,0,0, 0,1,1, tg(0,0,0,2,0,0,0,0), 0);
    vecs[15] = mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,1, tg(0,0,0,1,0,0,0,0), 0);
    vecs[16] = mk(1,1,1,0,4, 0,0,0,0, 1,0,0, 0,0,1, tg(0,0,0,0,0,0,0,0), 0);
    vecs[17] = mk(1,1,1,1,7, 0,0,0,0, 0,0,0, 0,1,0, tg(3,0,0,0,0,0,0,0), 0);
    vecs[18] = mk(1,1,1,0,0, 0,0,1,7, 1,0,0, 1,0,1, tg(2,0,0,0,0,0,0,0), 0);
    vecs[19] = mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,1, tg(1,0,0,0,0,0,0,0), 0);
    vecs[20] = mk(1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,1, tg(0,0,0,0,0,0,0,0), 0);
    vecs[21] = mk(1,1,1,1,1, 0,0,0,0, 0,0,0, 0,1,0, tg(0,0,0,0,0,0,3,0), 0);
    vecs[22] = mk(1,0,0,0,0, 0,0,0,0, 0,1,0, 0,0,1, tg(0,0,0,0,0,0,2,0), 0);
    vecs[23] = mk(1,1,1,0,0, 0,0,0,0, 0,1,0, 0,0,1, tg(0,0,0,0,0,0,1,0), 0);
    vecs[24] = mk(1,0,0,0,0, 0,0,0,0, 0,1,0, 0,0,1, tg(0,0,0,0,0,0,0,0), 0);
    vecs[25] = mk(1,0,0,0,0, 0,0,0,0, 0,1,0, 0,0,0, tg(0,0,0,0,0,0,0,0), 1);
    vecs[26] = mk(1,1,1,0,0, 0,0,0,0, 0,0,0, 0,0,0, tg(0,0,0,0,0,0,0,0), 1);
    vecs[27] = mk(1,0,0,0,0, 0,0,0,0, 0,0,1, 0,0,0, tg(0,0,0,0,0,0,0,0), 0);
    vecs[28] = mk(1,1,1,0,0, 0,0,0,0, 0,0,0, 0,1,0, tg(0,0,0,0,0,0,0,2), 0);
    vecs[29] = mk(1,0,0,0,0, 0,0,0,0, 0,1,0, 0,0,1, tg(0,0,0,0,0,0,0,1), 0);
    vecs[30] = mk(1,1,1,0,3, 0,0,0,0, 0,0,0, 0,0,1, tg(0,0,0,0,0,0,0,0), 0);
    vecs[31] = mk(1,1,1,0,3, 0,0,0,0, 0,0,0, 0,1,0, tg(0,0,0,0,2,0,0,0), 0);

    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("reset tags", 32'(register_invalid_o), 32'd0);
    check("reset halted", 32'(halted_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset accept idle", 32'(issue_accept_o), 32'd0);
    check("reset stall idle", 32'(load_use_stall_o), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 32; i++) apply(i, vecs[i]);

    // Mid-cycle async reset while r3 is pending: clears with no clock edge.
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst tags", 32'(register_invalid_o), 32'd0);
    check("async rst busy", 32'(busy_o), 32'd0);
    check("async rst halted", 32'(halted_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    issue_valid_i = 1'b1;
    #1;
    check("post rst accept", 32'(issue_accept_o), 32'd1);
    issue_valid_i = 1'b0;
    @(negedge clk);

    // Halt request while idle: HALTED on the very next edge.
    halt_req_i = 1'b1;
    @(posedge clk); #1;
    check("idle halt 1 edge", 32'(halted_o), 32'd1);
    halt_req_i = 1'b0;
    issue_valid_i = 1'b1;
    #1;
    check("halted blocks issue", 32'(issue_accept_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async rst leaves halt", 32'(halted_o), 32'd0);
    check("async rst accept", 32'(issue_accept_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
